// File: rtl/rbp_pkg.sv
// -----------------------------------------------------------------------------
// rbp_pkg
// Definitions shared by the rbp register-bus initiator and its users.
//   - Command codes. They are opaque to the host and only named here, so that
//     callers and responder benches use the same values.
//   - Bus widths.
//   - The host state encoding.
// -----------------------------------------------------------------------------
package rbp_pkg;

    localparam int RBP_CMD_W  = 4;
    localparam int RBP_DATA_W = 16;

    localparam logic [RBP_CMD_W-1:0] RBP_RESET_ADDR = 4'd0;
    localparam logic [RBP_CMD_W-1:0] RBP_READ       = 4'd1;
    localparam logic [RBP_CMD_W-1:0] RBP_POS_LO     = 4'd2;
    localparam logic [RBP_CMD_W-1:0] RBP_POS_HI     = 4'd3;
    localparam logic [RBP_CMD_W-1:0] RBP_FETCH      = 4'd4;
    localparam logic [RBP_CMD_W-1:0] RBP_START      = 4'd5;
    localparam logic [RBP_CMD_W-1:0] RBP_STOP       = 4'd6;
    localparam logic [RBP_CMD_W-1:0] RBP_TEST       = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_REQ,
        ST_RELEASE,
        ST_ABORT
    } rbp_state_t;

endpackage

// File: rtl/rbp_sync.sv
// -----------------------------------------------------------------------------
// rbp_sync
// A STAGES-deep flip-flop chain that brings one asynchronous bit into the
// i_clk domain. STAGES must be at least 2.
//   i_clk : destination clock
//   i_rst : synchronous active-high reset; the chain is cleared so a stale
//           level cannot leak out of reset
//   i_d   : asynchronous input bit
//   o_q   : synchronized bit, STAGES clocks behind i_d
// -----------------------------------------------------------------------------
module rbp_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // NOTE: flops are written with non-blocking assignments. Every stage then
    // samples its neighbour's old value, so the chain shifts by exactly one
    // stage per clock and cannot collapse in a single clock.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/rbp_host.sv
// -----------------------------------------------------------------------------
// rbp_host
// Initiator for the rbp register-bus protocol. A local user issues a single
// command or a burst of one command through a valid/ready port. The host runs
// one four-phase req/ack handshake per transaction and returns one 16-bit
// response for each transaction that completes. When an ack edge does not
// arrive in time, the host aborts and pulses rbp_rst to clear the responder.
//
// Parameters
//   SYNC_STAGES : depth of the synchronizer on rbp_ack (minimum 2)
//   TIMEOUT     : number of cycles to wait for an ack edge before aborting
//   LEN_W       : width of the burst-length field
//   RST_CYCLES  : length of the rbp_rst pulse after a timeout
//
// Ports
//   sys_clk, sys_rst : clock and synchronous active-high reset
//   cmd_valid/ready  : command handshake. Ready is high only in IDLE.
//   cmd_code         : rbp command code, passed through without decoding
//   cmd_len          : number of transactions; 0 is treated as 1
//   rsp_valid        : one-cycle pulse for each completed transaction
//   rsp_data         : rbp_data captured at that transaction's ack
//   rsp_last         : marks the final rsp_valid of a burst
//   err              : one-cycle pulse on timeout
//   busy             : host is not in IDLE
//   rbp_req/cmd/rst/dat : bus outputs to the responder; rbp_dat is constant 0
//   rbp_ack, rbp_data   : bus inputs from the responder (asynchronous)
// -----------------------------------------------------------------------------
module rbp_host
    import rbp_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023,
    parameter int LEN_W       = 16,
    parameter int RST_CYCLES  = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [RBP_CMD_W-1:0]  cmd_code,
    input  logic [LEN_W-1:0]      cmd_len,

    output logic                  rsp_valid,
    output logic [RBP_DATA_W-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  err,
    output logic                  busy,

    output logic                  rbp_req,
    output logic [RBP_CMD_W-1:0]  rbp_cmd,
    output logic                  rbp_rst,
    output logic                  rbp_dat,
    input  logic                  rbp_ack,
    input  logic [RBP_DATA_W-1:0] rbp_data
);

    // The timeout counter stops at TIMEOUT-1 and the abort counter stops at
    // RST_CYCLES-1, so each counter is sized for its own terminal count.
    localparam int TMO_W   = (TIMEOUT    > 1) ? $clog2(TIMEOUT)    : 1;
    localparam int ABORT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    rbp_state_t            r_state,     w_state_nxt;
    logic [RBP_CMD_W-1:0]  r_cmd,       w_cmd_nxt;
    logic [LEN_W-1:0]      r_remain,    w_remain_nxt;
    logic [TMO_W-1:0]      r_tmo,       w_tmo_nxt;
    logic [ABORT_W-1:0]    r_abort_cnt, w_abort_cnt_nxt;
    logic                  r_req,       w_req_nxt;
    logic                  r_rst,       w_rst_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic [RBP_DATA_W-1:0] r_rsp_data,  w_rsp_data_nxt;
    logic                  r_rsp_last,  w_rsp_last_nxt;
    logic                  r_err,       w_err_nxt;

    logic                  w_ack_s;
    logic                  w_tmo_hit;

    rbp_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .i_clk (sys_clk),
        .i_rst (sys_rst),
        .i_d   (rbp_ack),
        .o_q   (w_ack_s)
    );

    // The counter holds k during the k-th cycle after entering REQ or RELEASE.
    // Detecting TIMEOUT-1 here lets the abort, registered at this edge, show
    // up exactly TIMEOUT cycles after entry.
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every next-state value gets a default first. No path through
        // the case statement leaves a signal unassigned, which would infer a
        // latch.
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_remain_nxt    = r_remain;
        w_tmo_nxt       = r_tmo;
        w_abort_cnt_nxt = r_abort_cnt;
        w_req_nxt       = r_req;
        w_rst_nxt       = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_last_nxt  = 1'b0;
        w_err_nxt       = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_cmd_nxt    = cmd_code;
                    w_remain_nxt = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
                    w_state_nxt  = ST_SETUP;
                end
            end

            // rbp_cmd has been stable for one full cycle before req rises.
            ST_SETUP: begin
                w_req_nxt   = 1'b1;
                w_tmo_nxt   = '0;
                w_state_nxt = ST_REQ;
            end

            ST_REQ: begin
                if (w_ack_s) begin
                    // rbp_data is sampled directly. The responder has held it
                    // since before ack rose, which is at least SYNC_STAGES
                    // cycles of settling.
                    w_rsp_data_nxt  = rbp_data;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_last_nxt  = (r_remain == LEN_W'(1));
                    w_remain_nxt    = r_remain - LEN_W'(1);
                    w_req_nxt       = 1'b0;
                    w_tmo_nxt       = '0;
                    w_state_nxt     = ST_RELEASE;
                end else if (w_tmo_hit) begin
                    w_req_nxt       = 1'b0;
                    w_err_nxt       = 1'b1;
                    w_rst_nxt       = 1'b1;
                    w_abort_cnt_nxt = '0;
                    w_state_nxt     = ST_ABORT;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end

            ST_RELEASE: begin
                if (!w_ack_s) begin
                    w_state_nxt = (r_remain != '0) ? ST_SETUP : ST_IDLE;
                end else if (w_tmo_hit) begin
                    w_err_nxt       = 1'b1;
                    w_rst_nxt       = 1'b1;
                    w_abort_cnt_nxt = '0;
                    w_state_nxt     = ST_ABORT;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end

            // rbp_rst was raised on entry and is held through the terminal
            // count, giving exactly RST_CYCLES high cycles. The rest of the
            // burst is dropped.
            ST_ABORT: begin
                if (r_abort_cnt == ABORT_W'(RST_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_rst_nxt       = 1'b1;
                    w_abort_cnt_nxt = r_abort_cnt + ABORT_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            // NOTE: the response data register is cleared along with the
            // control state. Every registered output then has a defined value
            // out of reset, not just the ones that carry a valid strobe.
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_remain    <= '0;
            r_tmo       <= '0;
            r_abort_cnt <= '0;
            r_req       <= 1'b0;
            r_rst       <= 1'b1;  // held during reset to clear a stale responder ack
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd       <= w_cmd_nxt;
            r_remain    <= w_remain_nxt;
            r_tmo       <= w_tmo_nxt;
            r_abort_cnt <= w_abort_cnt_nxt;
            r_req       <= w_req_nxt;
            r_rst       <= w_rst_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_last  <= w_rsp_last_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_last  = r_rsp_last;
    assign err       = r_err;
    assign rbp_req   = r_req;
    assign rbp_cmd   = r_cmd;
    assign rbp_rst   = r_rst;
    assign rbp_dat   = 1'b0;

endmodule

// File: tb/tb_rbp_host.sv
// -----------------------------------------------------------------------------
// tb_rbp_host
// Self-checking bench for rbp_host. A responder process answers rbp_req and
// records, for each ack it raises, the cycle in which the matching rsp_valid
// must appear (ack cycle + SYNC_STAGES + 1), the data, and whether the word
// ends the burst. A compare process checks the outputs on every cycle against
// that expectation and against the reset/abort windows. Directed tests add
// hand-computed latencies and counts.
// -----------------------------------------------------------------------------
module tb_rbp_host;
    import rbp_pkg::*;

    localparam int SYNC  = 2;
    localparam int TMO   = 1023;
    localparam int RSTC  = 4;
    localparam int LEN_W = 16;

    logic             sys_clk;
    logic             sys_rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_code;
    logic [LEN_W-1:0] cmd_len;
    logic             rsp_valid;
    logic [15:0]      rsp_data;
    logic             rsp_last;
    logic             err;
    logic             busy;
    logic             rbp_req;
    logic [3:0]       rbp_cmd;
    logic             rbp_rst;
    logic             rbp_dat;
    logic             rbp_ack;
    logic [15:0]      rbp_data;

    rbp_host #(
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TMO),
        .LEN_W       (LEN_W),
        .RST_CYCLES  (RSTC)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .cmd_len   (cmd_len),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .err       (err),
        .busy      (busy),
        .rbp_req   (rbp_req),
        .rbp_cmd   (rbp_cmd),
        .rbp_rst   (rbp_rst),
        .rbp_dat   (rbp_dat),
        .rbp_ack   (rbp_ack),
        .rbp_data  (rbp_data)
    );

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] data_q[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    int          n_rsp = 0;
    int          n_rise = 0;
    int          n_rst_hi = 0;
    int          last_rsp_cyc = 0;
    int          prev_rsp_cyc = 0;
    logic [15:0] last_rsp_data = '0;
    logic        last_rsp_last = 1'b0;
    int          rise_cyc = 0;
    int          fall_cyc = 0;
    int          last_gap = 0;
    bit          rise_valid = 1'b0;
    int          abort_start = 0;
    bit          abort_valid = 1'b0;
    bit          tmo_mode = 1'b0;
    logic [3:0]  exp_cmd = '0;
    int          mdl_remain = 0;
    int          resp_delay = 0;
    bit          resp_en = 1'b1;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Responder: raises ack resp_delay cycles after it sees req high, with the
    // data already in place. It drops ack once req falls.
    initial begin
        exp_t e;
        int   wcnt;
        rbp_ack  = 1'b0;
        rbp_data = '0;
        wcnt     = 0;
        forever begin
            @(posedge sys_clk);
            #2;
            if (sys_rst) begin
                rbp_ack = 1'b0;
                wcnt    = 0;
            end else if (rbp_ack) begin
                if (!rbp_req) rbp_ack = 1'b0;
            end else if (rbp_req && resp_en) begin
                if (wcnt >= resp_delay) begin
                    if (data_q.size() != 0) rbp_data = data_q.pop_front();
                    else                    rbp_data = 16'hdead;
                    rbp_ack = 1'b1;
                    wcnt    = 0;
                    e.cyc   = cyc + SYNC + 1;
                    e.data  = rbp_data;
                    e.last  = (mdl_remain == 1);
                    exp_q.push_back(e);
                    if (mdl_remain > 0) mdl_remain--;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Compare process: checks every cycle, sampling at the falling edge.
    initial begin
        bit rst_prev;
        bit req_prev;
        bit exp_v;
        bit exp_err;
        bit exp_rst;
        rst_prev = 1'b1;
        req_prev = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (rst_prev) begin
                check("rst_req",       rbp_req,   1'b0);
                check("rst_rbp_rst",   rbp_rst,   1'b1);
                check("rst_rsp_valid", rsp_valid, 1'b0);
                check("rst_err",       err,       1'b0);
                check("rst_ready",     cmd_ready, 1'b1);
            end else begin
                while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                    check("rsp_missing_cycle", exp_q[0].cyc, cyc);
                    void'(exp_q.pop_front());
                end
                exp_v = 1'b0;
                if (exp_q.size() != 0) exp_v = (exp_q[0].cyc == cyc);
                check("rsp_valid", rsp_valid, exp_v);
                if (exp_v) begin
                    check("rsp_data", rsp_data, exp_q[0].data);
                    check("rsp_last", rsp_last, exp_q[0].last);
                    void'(exp_q.pop_front());
                end
                if (rsp_valid) begin
                    n_rsp++;
                    prev_rsp_cyc  = last_rsp_cyc;
                    last_rsp_cyc  = cyc;
                    last_rsp_data = rsp_data;
                    last_rsp_last = rsp_last;
                end
                if (rbp_req && !req_prev) begin
                    n_rise++;
                    last_gap   = cyc - fall_cyc;
                    rise_cyc   = cyc;
                    rise_valid = 1'b1;
                end
                if (!rbp_req && req_prev) fall_cyc = cyc;
                if (rbp_req) check("rbp_cmd", rbp_cmd, exp_cmd);

                exp_err = tmo_mode && rise_valid && (cyc == rise_cyc + TMO);
                if (exp_err) begin
                    abort_start = cyc;
                    abort_valid = 1'b1;
                end
                check("err", err, exp_err);
                exp_rst = abort_valid && (cyc >= abort_start) && (cyc < abort_start + RSTC);
                check("rbp_rst", rbp_rst, exp_rst);
                if (rbp_rst) n_rst_hi++;
                check("rbp_dat", rbp_dat, 1'b0);
                check("ready_vs_busy", cmd_ready, !busy);
            end
            req_prev = rbp_req;
            rst_prev = sys_rst;
        end
    end

    task automatic issue(input logic [3:0] code, input logic [LEN_W-1:0] len, output int acc);
        @(posedge sys_clk);
        #1;
        cmd_valid  = 1'b1;
        cmd_code   = code;
        cmd_len    = len;
        exp_cmd    = code;
        mdl_remain = (len == 0) ? 1 : int'(len);
        acc        = cyc;
        @(posedge sys_clk);
        #1;
        cmd_valid  = 1'b0;
        check("accept_busy", busy, 1'b1);
    endtask

    task automatic poke(input logic [3:0] code, input logic [LEN_W-1:0] len);
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_len   = len;
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int i = 0;
        while (n_rsp < n && i < budget) begin
            @(posedge sys_clk);
            #1;
            i++;
        end
        check("rsp_count_reached", n_rsp, n);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (!cmd_ready && i < budget) begin
            @(posedge sys_clk);
            #1;
            i++;
        end
        check("idle_ready", cmd_ready, 1'b1);
        check("idle_busy",  busy,      1'b0);
    endtask

    initial begin
        int acc;
        int err_cyc;
        bit found;

        sys_rst   = 1'b1;
        cmd_valid = 1'b0;
        cmd_code  = '0;
        cmd_len   = '0;

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_ready",   cmd_ready, 1'b1);
        check("reset_busy",    busy,      1'b0);
        check("reset_rbp_rst", rbp_rst,   1'b1);
        check("reset_req",     rbp_req,   1'b0);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        check("release_rbp_rst", rbp_rst, 1'b0);

        // TEST command, immediate ack: req at acc+2, ack at acc+2, rsp at acc+5
        data_q.push_back(16'h1234);
        resp_delay = 0;
        n_rsp = 0; n_rise = 0;
        issue(RBP_TEST, 16'd1, acc);
        wait_rsp(1, 50);
        check("test_latency", last_rsp_cyc - acc, 5);
        check("test_data",    last_rsp_data,      16'h1234);
        check("test_last",    last_rsp_last,      1'b1);
        wait_idle(20);
        check("test_req_rises", n_rise, 1);

        // Burst read of 3: words 7 cycles apart, req low for 4 cycles between them
        data_q.push_back(16'h0010);
        data_q.push_back(16'h0011);
        data_q.push_back(16'h0012);
        n_rsp = 0; n_rise = 0;
        issue(RBP_READ, 16'd3, acc);
        wait_rsp(3, 200);
        check("burst_spacing",  last_rsp_cyc - prev_rsp_cyc, 7);
        check("burst_req_gap",  last_gap,      SYNC + 2);
        check("burst_last_dat", last_rsp_data, 16'h0012);
        check("burst_last",     last_rsp_last, 1'b1);
        wait_idle(20);
        check("burst_rsp_cnt",  n_rsp,  3);
        check("burst_req_cnt",  n_rise, 3);

        // Zero length is one transaction; a two-cycle responder delay gives acc+7
        data_q.push_back(16'h00a5);
        resp_delay = 2;
        n_rsp = 0; n_rise = 0;
        issue(RBP_POS_LO, 16'd0, acc);
        wait_rsp(1, 50);
        check("zero_latency", last_rsp_cyc - acc, 7);
        check("zero_last",    last_rsp_last, 1'b1);
        wait_idle(20);
        repeat (10) @(posedge sys_clk);
        #1;
        check("zero_rsp_cnt", n_rsp,  1);
        check("zero_req_cnt", n_rise, 1);

        // Busy rejection: new commands offered during REQ and RELEASE are dropped
        data_q.push_back(16'h0020);
        data_q.push_back(16'h0021);
        data_q.push_back(16'h0022);
        resp_delay = 1;
        n_rsp = 0; n_rise = 0;
        issue(RBP_READ, 16'd3, acc);
        repeat (2) @(posedge sys_clk);
        #1;
        poke(RBP_FETCH, 16'd7);
        wait_rsp(1, 50);
        poke(RBP_STOP, 16'd2);
        wait_rsp(3, 200);
        wait_idle(20);
        repeat (20) @(posedge sys_clk);
        #1;
        check("busy_rsp_cnt", n_rsp,  3);
        check("busy_req_cnt", n_rise, 3);

        // Timeout: no ack -> err at REQ entry + TMO = acc + 2 + TMO, then RSTC rbp_rst cycles
        tmo_mode    = 1'b1;
        rise_valid  = 1'b0;
        abort_valid = 1'b0;
        resp_en     = 1'b0;
        n_rsp = 0; n_rst_hi = 0;
        issue(RBP_FETCH, 16'd4, acc);
        found   = 1'b0;
        err_cyc = 0;
        for (int i = 0; i < TMO + 50 && !found; i++) begin
            @(negedge sys_clk);
            if (err) begin
                found   = 1'b1;
                err_cyc = cyc;
            end
        end
        check("tmo_err_seen",  found,         1'b1);
        check("tmo_err_cycle", err_cyc - acc, 2 + TMO);
        repeat (RSTC + 2) @(posedge sys_clk);
        #1;
        check("tmo_rst_cycles", n_rst_hi,  RSTC);
        check("tmo_ready",      cmd_ready, 1'b1);
        check("tmo_no_rsp",     n_rsp,     0);
        tmo_mode = 1'b0;
        resp_en  = 1'b1;

        // Mid-burst reset during the second word of a len-5 READ
        for (int i = 0; i < 5; i++) data_q.push_back(16'h0030 + 16'(i));
        resp_delay = 6;
        n_rsp = 0;
        issue(RBP_READ, 16'd5, acc);
        wait_rsp(1, 100);
        begin
            int i = 0;
            while (!rbp_req && i < 50) begin
                @(posedge sys_clk);
                #1;
                i++;
            end
        end
        check("midrst_second_req", rbp_req, 1'b1);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst    = 1'b1;
        data_q.delete();
        exp_q.delete();
        mdl_remain = 0;
        @(posedge sys_clk);
        #1;
        check("midrst_req",       rbp_req,   1'b0);
        check("midrst_rbp_rst",   rbp_rst,   1'b1);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_ready",     cmd_ready, 1'b1);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("midrst_rsp_cnt", n_rsp, 1);

        data_q.push_back(16'h1234);
        resp_delay = 0;
        n_rsp = 0;
        issue(RBP_TEST, 16'd1, acc);
        wait_rsp(1, 50);
        check("post_rst_latency", last_rsp_cyc - acc, 5);
        check("post_rst_data",    last_rsp_data, 16'h1234);
        check("post_rst_last",    last_rsp_last, 1'b1);
        wait_idle(20);

        repeat (5) @(posedge sys_clk);
        #1;
        check("model_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rbp_host.md
# rbp_host

Initiator for the rbp register-bus protocol: it drives `rbp_req`, `rbp_cmd`, `rbp_rst` and `rbp_dat`, and collects `rbp_ack` and `rbp_data` from an rbp responder, such as the UART/SDRAM/ADC capture controller. A local user issues single or burst commands through a valid/ready port and gets one 16-bit response per completed transaction. The block sits on the FPGA that masters the capture board and is also used as the bench driver for responder tests. Responder inputs are treated as asynchronous and are synchronized.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `rbp_ack`; minimum 2.
- `TIMEOUT`, default 1023: maximum cycles spent waiting on an ack edge before abort.
- `LEN_W`, default 16: width of the burst length field.
- `RST_CYCLES`, default 4: `rbp_rst` pulse length after a timeout.
- `sys_clk`, in, 1: single clock.
- `sys_rst`, in, 1: synchronous, active-high reset.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: high only in IDLE.
- `cmd_code`, in, 4: rbp command code.
- `cmd_len`, in, LEN_W: number of transactions; 0 is treated as 1.
- `rsp_valid`, out, 1: one-cycle pulse per completed transaction.
- `rsp_data`, out, 16: captured `rbp_data`.
- `rsp_last`, out, 1: qualifies the final `rsp_valid` of a burst.
- `err`, out, 1: one-cycle pulse on timeout.
- `busy`, out, 1: state ≠ IDLE.
- `rbp_req`, out, 1: request strobe.
- `rbp_cmd`, out, 4: command code, stable whenever `rbp_req` is high.
- `rbp_rst`, out, 1: responder handshake reset.
- `rbp_dat`, out, 1: reserved; constant 0.
- `rbp_ack`, in, 1: responder acknowledge (asynchronous).
- `rbp_data`, in, 16: responder data, valid while `rbp_ack` is high.

## Operation
- **States:** IDLE, SETUP, REQ, RELEASE, ABORT.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `cmd_code` into `rbp_cmd` and load `remain` = max(`cmd_len`,1) → SETUP.
- **SETUP:** one cycle with `rbp_cmd` stable and `rbp_req`=0. Then `rbp_req`←1, clear the timeout counter → REQ.
- **REQ:**
  - Wait for `ack_s`=1, where `ack_s` is `rbp_ack` after SYNC_STAGES flops.
  - On `ack_s`=1: `rsp_data`←`rbp_data`, `rsp_valid`←1, `rsp_last`←(`remain`==1), `remain`←`remain`−1, `rbp_req`←0, clear timeout → RELEASE.
- **RELEASE:** wait for `ack_s`=0. Then go to SETUP if `remain`≠0, else IDLE.
- **Timeout:**
  - A counter increments in REQ and RELEASE.
  - When it reaches TIMEOUT: `rbp_req`←0, `err`←1 → ABORT.
- **ABORT:**
  - `rbp_rst`=1 for RST_CYCLES cycles, then → IDLE.
  - The rest of the burst is discarded. No `rsp_valid` is produced for the aborted transaction.
- **While not IDLE:** `cmd_valid` is ignored and the command is not queued.
- **Data capture:** `rbp_data` is sampled without synchronization. This is legal because the responder holds it from before its ack rise until req falls, so at least SYNC_STAGES cycles of settling have elapsed.
- **Commands:** codes are opaque to the block. Every code, including RESET_ADDR, START and STOP, returns one `rsp_valid`; the data is don't-care for non-data codes.

## Timing
- **Reset values:**
  - `rbp_rst`=1 during `sys_rst`, deasserting in the first cycle after reset. This clears any stale responder ack.
  - All other registered outputs are 0.
  - `cmd_ready`=1 after reset (IDLE).
- **Latency:**
  - Accept at cycle 0.
  - `rbp_cmd` valid at cycle 1.
  - `rbp_req` high at cycle 2.
  - Responder raises ack at cycle A; `rsp_valid` fires at A+SYNC_STAGES+1.
  - `rbp_req` drops in the same cycle `rsp_valid` is registered.
- **Burst spacing:** at least SYNC_STAGES+2 cycles of `rbp_req` low between transactions.
- **Timeout:** `err` fires exactly TIMEOUT cycles after entry to REQ or RELEASE if no ack edge is seen.
- **Reset during a transaction:** `rbp_req` drops, `rbp_rst` asserts, state goes to IDLE, and no `rsp_valid` or `err` is produced.
- **`remain` arithmetic:** never wraps. A `cmd_len` of 2^LEN_W−1 yields exactly that many transactions.

## Structure
- Package `rbp_pkg` holds:
  - command constants: RBP_RESET_ADDR=0, RBP_READ=1, RBP_POS_LO=2, RBP_POS_HI=3, RBP_FETCH=4, RBP_START=5, RBP_STOP=6, RBP_TEST=15;
  - the state enum.
- Sub-module `rbp_sync`: a parameterized N-flop single-bit synchronizer, used for `rbp_ack`.

## Test plan
- **TEST command:** RBP_TEST, len 1, responder returns 0x1234 → one `rsp_valid` with `rsp_data`=0x1234 and `rsp_last`=1; `rbp_req` is high for exactly one handshake.
- **Burst read:** RBP_READ, len 3, responder returns 0x0010, 0x0011, 0x0012 → three `rsp_valid` pulses in order, `rsp_last` only on the third, `rbp_req` low between them, `busy` cleared afterwards.
- **Zero length:** len 0 with RBP_POS_LO → exactly one transaction, `rsp_last`=1.
- **Timeout:** responder never acks, TIMEOUT=1023 → `err` one cycle exactly 1023 cycles after REQ entry, then `rbp_rst` high for 4 cycles, `cmd_ready`=1 after, and no `rsp_valid`.
- **Busy rejection:** `cmd_valid` pulsed during a burst → ignored; the transaction count equals the original length.
- **Mid-burst reset:** `sys_rst` asserted during the second word of a len-5 READ → `rbp_req`=0, `rbp_rst`=1, `rsp_valid`=0. After release, a RBP_TEST command completes normally with 0x1234.
